// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-0 slave giving an external master access to a
// bank of 2^ADDR_W 8-bit registers with a two-byte command/data frame.
// Byte 0 = {rnw, addr[6:0]}, byte 1 = data. All SPI inputs are oversampled
// and synchronised in the clk domain. A host port gives local access to the
// same registers.
//
// Optional feature: define SPI_REG_AUTOINC_EN to turn the post-data HOLD phase
// into a burst where each further byte targets the next address (mod depth).
//
// Ports:
//   clk, rst_n             system clock, async active-low reset
//   spi_clk/mosi/cs_n      SPI bus inputs from the master (asynchronous)
//   spi_miso               serial data to the master, MSB first, 0 when idle
//   host_addr/we/wdata     host write port
//   host_rdata             combinational read of reg[host_addr]
//   wr_valid/addr/data     one-cycle notification of an SPI register write
module spi_reg_responder #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CMD_AW = 7;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Synchronisers: [0],[1] are the two sync stages, [2] is the edge register.
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [2:0] cs_q;

  logic              sclk_rise_c, sclk_fall_c;
  logic              cs_high_c, cs_fall_c;
  logic              mosi_c;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_byte_c;
  logic              last_bit_c;

  logic              rnw_q;
  logic              in_range_q;
  logic [ADDR_W-1:0] addr_q;

  logic [CMD_AW-1:0] cmd_addr_c;
  logic              cmd_in_range_c;
  logic [ADDR_W-1:0] cmd_idx_c;

  logic              shift_c, cmd_done_c, byte_done_c, tx_shift_c, commit_c;

  logic [DATA_W-1:0] regs [DEPTH];

  // Input synchronisation. cs resets to "selected" so that a frame already in
  // progress at reset release does not look like a new falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
      cs_q   <= 3'b000;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk};
      mosi_q <= {mosi_q[0], spi_mosi};
      cs_q   <= {cs_q[1:0], spi_cs_n};
    end
  end

  assign sclk_rise_c = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_c = ~sclk_q[1] & sclk_q[2];
  assign cs_high_c   = cs_q[1];
  assign cs_fall_c   = ~cs_q[1] & cs_q[2];
  assign mosi_c      = mosi_q[1];

  assign rx_byte_c  = {rx_sr, mosi_c};
  assign last_bit_c = (bit_cnt == CNT_W'(7));

  // Command decode of the byte completing on this rising edge.
  assign cmd_addr_c     = rx_byte_c[CMD_AW-1:0];
  assign cmd_in_range_c = ((cmd_addr_c >> ADDR_W) == CMD_AW'(0));
  assign cmd_idx_c      = cmd_addr_c[ADDR_W-1:0];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; a deselect overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cs_fall_c) state_nxt = ST_CMD;
      ST_CMD:  if (sclk_rise_c && last_bit_c) state_nxt = ST_DATA;
`ifdef SPI_REG_AUTOINC_EN
      ST_DATA: state_nxt = ST_DATA;
`else
      ST_DATA: if (sclk_rise_c && last_bit_c) state_nxt = ST_HOLD;
`endif
      ST_HOLD: state_nxt = ST_HOLD;
      default: state_nxt = ST_IDLE;
    endcase
    if (cs_high_c) state_nxt = ST_IDLE;
  end

  // FSM control strobes for the datapath.
  always_comb begin
    shift_c     = 1'b0;
    cmd_done_c  = 1'b0;
    byte_done_c = 1'b0;
    tx_shift_c  = 1'b0;
    if (!cs_high_c) begin
      case (state)
        ST_CMD: begin
          shift_c    = sclk_rise_c;
          cmd_done_c = sclk_rise_c & last_bit_c;
        end
        ST_DATA: begin
          shift_c     = sclk_rise_c;
          byte_done_c = sclk_rise_c & last_bit_c;
          tx_shift_c  = sclk_fall_c;
        end
        default: ;
      endcase
    end
    commit_c = byte_done_c & ~rnw_q & in_range_q;
  end

  // Bit counter and receive shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
    end else begin
      if (state == ST_IDLE || cs_high_c) bit_cnt <= '0;
      else if (shift_c)                  bit_cnt <= bit_cnt + CNT_W'(1);
      if (shift_c) rx_sr <= rx_byte_c[DATA_W-2:0];
    end
  end

`ifdef SPI_REG_AUTOINC_EN
  logic [ADDR_W-1:0] addr_inc_c;
  assign addr_inc_c = addr_q + ADDR_W'(1);
`endif

  // Command latch and transmit snapshot/shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnw_q      <= 1'b0;
      in_range_q <= 1'b0;
      addr_q     <= '0;
      tx_sr      <= '0;
    end else if (cmd_done_c) begin
      rnw_q      <= rx_byte_c[DATA_W-1];
      in_range_q <= cmd_in_range_c;
      addr_q     <= cmd_idx_c;
      tx_sr      <= (rx_byte_c[DATA_W-1] && cmd_in_range_c) ? regs[cmd_idx_c] : 8'h00;
`ifdef SPI_REG_AUTOINC_EN
    end else if (byte_done_c) begin
      addr_q <= addr_inc_c;
      tx_sr  <= (rnw_q && in_range_q) ? regs[addr_inc_c] : 8'h00;
`endif
    end else if (tx_shift_c) begin
      tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
    end
  end

  // MISO: next snapshot bit on each falling edge while in DATA, else 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           spi_miso <= 1'b0;
    else if (cs_high_c)   spi_miso <= 1'b0;
    else if (sclk_fall_c) spi_miso <= (state == ST_DATA) ? tx_sr[DATA_W-1] : 1'b0;
  end

  // Register bank; an SPI commit wins over a host write to the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (commit_c && addr_q == ADDR_W'(i))
          regs[i] <= rx_byte_c;
        else if (host_we && host_addr == ADDR_W'(i))
          regs[i] <= host_wdata;
      end
    end
  end

  // SPI write notification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= commit_c;
      if (commit_c) begin
        wr_addr <= addr_q;
        wr_data <= rx_byte_c;
      end
    end
  end

  assign host_rdata = regs[host_addr];

endmodule
